// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
package router_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned LEN_W        = 6;
  localparam int unsigned ADDR_W       = 2;
  localparam int unsigned MAX_LEN      = 63;
  localparam int unsigned CHECK_CYCLES = 2;

  localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PARITY,
    CHECK
  } tx_state_e;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } hdr_t;

  // Header byte: length in the upper six bits, destination port in the lower two.
  function automatic logic [DATA_W-1:0] hdr_pack(input logic [LEN_W-1:0]  len,
                                                 input logic [ADDR_W-1:0] addr);
    hdr_t h;
    h.len  = len;
    h.addr = addr;
    return DATA_W'(h);
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload FIFO: 64x8 storage, first-word-fallthrough head, 6-bit occupancy (max 63).
module router_tx_buf
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data_c,
  output logic [LEN_W-1:0]  o_count
);

  localparam int unsigned DEPTH = 64;
  localparam int unsigned PTR_W = 6;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LEN_W-1:0]  r_count;
  logic              w_wr;
  logic              w_rd;

  assign w_wr = i_wr_en && (r_count != LEN_W'(MAX_LEN));
  assign w_rd = i_rd_en && (r_count != '0);

  // Pointer and occupancy tracking; flush empties the buffer like reset.
  always_ff @(posedge clock) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + LEN_W'(1);
        2'b01:   r_count <= r_count - LEN_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data_c = r_mem[r_rd_ptr];
  assign o_count     = r_count;

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet source: frames buffered payload as header/payload/parity under busy back-pressure.
module router_pkt_tx
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ovf,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  output logic              start_rej,
  output logic              tx_active,
  output logic              done,
  output logic              done_err,
  input  logic              busy,
  input  logic              router_err,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] data_in
);

  localparam int unsigned CHK_W = (CHECK_CYCLES > 1) ? $clog2(CHECK_CYCLES) : 1;

  tx_state_e         r_state,     w_state_nxt;
  logic [ADDR_W-1:0] r_addr,      w_addr_nxt;
  logic [LEN_W-1:0]  r_len,       w_len_nxt;
  logic [LEN_W-1:0]  r_cnt,       w_cnt_nxt;
  logic [CHK_W-1:0]  r_chk,       w_chk_nxt;
  logic [DATA_W-1:0] r_par,       w_par_nxt;
  logic [DATA_W-1:0] r_data,      w_data_nxt;
  logic              r_pkt_valid, w_pkt_valid_nxt;
  logic              r_tx_active, w_tx_active_nxt;
  logic              r_wr_ovf,    w_wr_ovf_nxt;
  logic              r_start_rej, w_start_rej_nxt;
  logic              r_done,      w_done_nxt;
  logic              r_done_err,  w_done_err_nxt;

  logic              w_start_ok;
  logic              w_buf_wr;
  logic              w_buf_rd;
  logic              w_buf_flush;
  logic [DATA_W-1:0] w_buf_head;
  logic [LEN_W-1:0]  w_buf_count;

  router_tx_buf u_buf (
    .clock       (clock),
    .reset       (reset),
    .i_flush     (w_buf_flush),
    .i_wr_en     (w_buf_wr),
    .i_wr_data   (wr_data),
    .i_rd_en     (w_buf_rd),
    .o_rd_data_c (w_buf_head),
    .o_count     (w_buf_count)
  );

  // State register and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_chk       <= '0;
      r_par       <= '0;
      r_data      <= '0;
      r_pkt_valid <= 1'b0;
      r_tx_active <= 1'b0;
      r_wr_ovf    <= 1'b0;
      r_start_rej <= 1'b0;
      r_done      <= 1'b0;
      r_done_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_len       <= w_len_nxt;
      r_cnt       <= w_cnt_nxt;
      r_chk       <= w_chk_nxt;
      r_par       <= w_par_nxt;
      r_data      <= w_data_nxt;
      r_pkt_valid <= w_pkt_valid_nxt;
      r_tx_active <= w_tx_active_nxt;
      r_wr_ovf    <= w_wr_ovf_nxt;
      r_start_rej <= w_start_rej_nxt;
      r_done      <= w_done_nxt;
      r_done_err  <= w_done_err_nxt;
    end
  end

  // Next-state and next-output logic. The buffer head is popped as it is
  // loaded into the output register, so r_data always holds the presented byte.
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_len_nxt       = r_len;
    w_cnt_nxt       = r_cnt;
    w_chk_nxt       = r_chk;
    w_par_nxt       = r_par;
    w_data_nxt      = r_data;
    w_pkt_valid_nxt = r_pkt_valid;
    w_wr_ovf_nxt    = 1'b0;
    w_done_nxt      = 1'b0;
    w_done_err_nxt  = r_done_err;
    w_buf_wr        = 1'b0;
    w_buf_rd        = 1'b0;
    w_buf_flush     = 1'b0;

    w_start_ok      = start && (r_state == IDLE) && (addr != ADDR_ILLEGAL) &&
                      (w_buf_count != '0);
    w_start_rej_nxt = start && !w_start_ok;

    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_state_nxt     = HEADER;
          w_addr_nxt      = addr;
          w_len_nxt       = w_buf_count;
          w_par_nxt       = '0;
          w_cnt_nxt       = '0;
          w_pkt_valid_nxt = 1'b1;
          w_data_nxt      = hdr_pack(w_buf_count, addr);
        end else if (wr_en) begin
          if (w_buf_count == LEN_W'(MAX_LEN)) w_wr_ovf_nxt = 1'b1;
          else                                w_buf_wr     = 1'b1;
        end
      end
      HEADER: begin
        if (!busy) begin
          w_state_nxt = PAYLOAD;
          w_par_nxt   = r_par ^ r_data;
          w_data_nxt  = w_buf_head;
          w_buf_rd    = 1'b1;
          w_cnt_nxt   = LEN_W'(1);
        end else begin
          w_data_nxt  = hdr_pack(r_len, r_addr);
        end
      end
      PAYLOAD: begin
        if (!busy) begin
          w_par_nxt = r_par ^ r_data;
          if (r_cnt == r_len) begin
            w_state_nxt     = PARITY;
            w_pkt_valid_nxt = 1'b0;
            w_data_nxt      = r_par ^ r_data;
          end else begin
            w_data_nxt = w_buf_head;
            w_buf_rd   = 1'b1;
            w_cnt_nxt  = r_cnt + LEN_W'(1);
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          w_state_nxt = CHECK;
          w_chk_nxt   = '0;
        end
      end
      CHECK: begin
        if (r_chk == CHK_W'(CHECK_CYCLES - 1)) begin
          w_state_nxt    = IDLE;
          w_done_nxt     = 1'b1;
          w_done_err_nxt = router_err;
          w_buf_flush    = 1'b1;
        end else begin
          w_chk_nxt = r_chk + CHK_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_tx_active_nxt = (w_state_nxt != IDLE);
  end

  assign pkt_valid = r_pkt_valid;
  assign data_in   = r_data;
  assign wr_ovf    = r_wr_ovf;
  assign start_rej = r_start_rej;
  assign tx_active = r_tx_active;
  assign done      = r_done;
  assign done_err  = r_done_err;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: stimulus queues expected events, a negedge monitor checks them.
module tb_router_pkt_tx;

  typedef struct {
    int   cyc;
    logic err;
  } done_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_ovf;
  logic       start;
  logic [1:0] addr;
  logic       start_rej;
  logic       tx_active;
  logic       done;
  logic       done_err;
  logic       busy;
  logic       router_err;
  logic       pkt_valid;
  logic [7:0] data_in;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] q_byte [$];
  done_t      q_done [$];
  int         q_rej  [$];
  int         q_ovf  [$];
  logic [7:0] vec    [$];

  bit         mon_en     = 1'b0;
  logic       hold_err   = 1'b0;
  bit         rst_pend   = 1'b0;
  bit         prev_pv    = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  logic [7:0] m_byte;
  done_t      m_done;
  int         m_cyc;

  router_pkt_tx dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_ovf     (wr_ovf),
    .start      (start),
    .addr       (addr),
    .start_rej  (start_rej),
    .tx_active  (tx_active),
    .done       (done),
    .done_err   (done_err),
    .busy       (busy),
    .router_err (router_err),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected no event (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a byte or a pulse.
  always @(negedge clock) begin
    if (mon_en) begin
      if (rst_pend) hold_err = 1'b0;
      if (prev_stall) begin
        chk("stall_pkt_valid", 32'(pkt_valid), 32'd1);
        chk("stall_data_in", 32'(data_in), 32'(prev_data));
      end
      if (pkt_valid && !busy && !reset) begin
        if (q_byte.size() == 0) fail_evt("unexpected_byte", 32'(data_in));
        else begin
          m_byte = q_byte.pop_front();
          chk("byte", 32'(data_in), 32'(m_byte));
        end
      end
      if (tx_active && !pkt_valid && prev_pv) begin
        if (q_byte.size() == 0) fail_evt("unexpected_parity", 32'(data_in));
        else begin
          m_byte = q_byte.pop_front();
          chk("parity", 32'(data_in), 32'(m_byte));
        end
      end
      if (done) begin
        if (q_done.size() == 0) fail_evt("unexpected_done", 32'(cyc));
        else begin
          m_done = q_done.pop_front();
          chk("done_cycle", 32'(cyc), 32'(m_done.cyc));
          chk("done_err", 32'(done_err), 32'(m_done.err));
          hold_err = m_done.err;
        end
      end else begin
        chk("done_err_hold", 32'(done_err), 32'(hold_err));
      end
      if (start_rej) begin
        if (q_rej.size() == 0) fail_evt("unexpected_start_rej", 32'(cyc));
        else begin
          m_cyc = q_rej.pop_front();
          chk("start_rej_cycle", 32'(cyc), 32'(m_cyc));
        end
      end
      if (wr_ovf) begin
        if (q_ovf.size() == 0) fail_evt("unexpected_wr_ovf", 32'(cyc));
        else begin
          m_cyc = q_ovf.pop_front();
          chk("wr_ovf_cycle", 32'(cyc), 32'(m_cyc));
        end
      end
      rst_pend   = reset;
      prev_pv    = pkt_valid;
      prev_stall = pkt_valid && busy && !reset;
      prev_data  = data_in;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_vec();
    foreach (vec[i]) begin
      wr_en   = 1'b1;
      wr_data = vec[i];
      tick();
    end
    wr_en   = 1'b0;
    wr_data = '0;
  endtask

  task automatic start_reject(input logic [1:0] a);
    q_rej.push_back(cyc + 1);
    start = 1'b1;
    addr  = a;
    tick();
    start = 1'b0;
    addr  = '0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((q_done.size() != 0 || tx_active) && i < 400) begin
      tick();
      i++;
    end
    if (i >= 400) begin
      fail_evt("timeout_waiting_done", 32'(i));
      q_byte.delete();
      q_done.delete();
    end
  endtask

  // Sends the packet held in vec; header/parity are hand-computed by the caller.
  task automatic send(input logic [1:0] a, input logic [7:0] hdr, input logic [7:0] par,
                      input int stall, input logic err, input bit rej_mid);
    int    t;
    int    e;
    int    len;
    done_t d;
    len = vec.size();
    q_byte.push_back(hdr);
    foreach (vec[i]) q_byte.push_back(vec[i]);
    q_byte.push_back(par);
    start = 1'b1;
    addr  = a;
    tick();
    start = 1'b0;
    addr  = '0;
    t     = cyc;
    e     = 0;
    d.cyc = t + 4 + len + stall;
    d.err = err;
    q_done.push_back(d);
    if (stall > 0) begin
      busy = 1'b1;
      repeat (stall) tick();
      busy = 1'b0;
      e += stall;
    end
    if (rej_mid) begin
      tick();
      e++;
      start_reject(2'd0);
      e++;
    end
    repeat (3 + len + stall - e) tick();
    router_err = err;
    tick();
    router_err = 1'b0;
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_data    = '0;
    start      = 1'b0;
    addr       = '0;
    busy       = 1'b0;
    router_err = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state of every output.
    chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    chk("rst_data_in",   32'(data_in),   32'd0);
    chk("rst_wr_ovf",    32'(wr_ovf),    32'd0);
    chk("rst_start_rej", 32'(start_rej), 32'd0);
    chk("rst_tx_active", 32'(tx_active), 32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_done_err",  32'(done_err),  32'd0);
    mon_en = 1'b1;

    // Start with an empty buffer is refused.
    start_reject(2'd0);
    tick();
    chk("empty_start_idle", 32'(tx_active), 32'd0);

    // Basic packet, with an illegal-address start first and a start during payload.
    vec = '{8'h01, 8'h02, 8'h04};
    write_vec();
    start_reject(2'd3);
    tick();
    chk("illegal_addr_idle", 32'(tx_active), 32'd0);
    send(2'd2, 8'h0E, 8'h09, 0, 1'b0, 1'b1);

    // Header held under three busy cycles; same parity, timing shifted by three.
    vec = '{8'h01, 8'h02, 8'h04};
    write_vec();
    send(2'd2, 8'h0E, 8'h09, 3, 1'b0, 1'b0);

    // Router error sampled at the end of CHECK, then cleared by the next packet.
    vec = '{8'hA5};
    write_vec();
    send(2'd0, 8'h04, 8'hA1, 0, 1'b1, 1'b0);
    repeat (3) tick();
    vec = '{8'h3C};
    write_vec();
    send(2'd1, 8'h05, 8'h39, 0, 1'b0, 1'b0);

    // Overflow: 63 bytes fill the buffer, the 64th write is dropped.
    vec.delete();
    for (int i = 0; i < 63; i++) vec.push_back(8'(i));
    write_vec();
    q_ovf.push_back(cyc + 1);
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    tick();
    wr_en   = 1'b0;
    send(2'd1, 8'hFD, 8'hC2, 0, 1'b0, 1'b0);

    // Reset during payload byte 2 abandons the packet and empties the buffer.
    vec = '{8'h11, 8'h22, 8'h33};
    write_vec();
    q_byte.push_back(8'h0C);
    q_byte.push_back(8'h11);
    start = 1'b1;
    addr  = 2'd0;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_pkt_valid", 32'(pkt_valid), 32'd0);
    chk("mid_rst_data_in",   32'(data_in),   32'd0);
    chk("mid_rst_tx_active", 32'(tx_active), 32'd0);
    chk("mid_rst_done",      32'(done),      32'd0);
    start_reject(2'd0);
    repeat (8) tick();
    chk("mid_rst_still_idle", 32'(tx_active), 32'd0);

    // Every queued expectation must have been consumed.
    chk("left_bytes", 32'(q_byte.size()), 32'd0);
    chk("left_done",  32'(q_done.size()), 32'd0);
    chk("left_rej",   32'(q_rej.size()),  32'd0);
    chk("left_ovf",   32'(q_ovf.size()),  32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
